// File: rtl/chain_result_capture.sv
// chain_result_capture: resync, stability-qualify and queue
// changed result words from the long clock-chain stage.
module chain_result_capture #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 8,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     en,
  input  logic                     clr,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         change_cnt,
  output logic                     overflow,
  output logic                     rsvd_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_QUAL = SW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] last_word;
  logic [SW-1:0]    stab_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    wptr;
  logic [LW-1:0]    rptr;

  logic qualify;
  logic accept;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic rsvd_set;

  assign qualify  = (s2 == cand) && (stab_cnt == STAB_QUAL);
  assign accept   = qualify && (cand != last_word) && en;
  assign rsvd_set = qualify && (cand[7:0] != 8'h00);

  assign level     = wptr - rptr;
  assign out_valid = (wptr != rptr);
  assign full      = (level == LW'(DEPTH));
  assign pop       = out_valid && out_ready;
  assign push      = accept && (!full || pop);
  assign drop      = accept && full && !pop;
  assign out_data  = out_valid ? mem[rptr[AW-1:0]] : '0;

  // two-flop resync of the whole bus
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= data_in;
      s2 <= s1;
    end
  end

  // stability filter; counter parks saturated after one qualify
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cand     <= '0;
      stab_cnt <= STAB_MAX;
    end else if (s2 != cand) begin
      cand     <= s2;
      stab_cnt <= '0;
    end else if (stab_cnt < STAB_MAX) begin
      stab_cnt <= stab_cnt + SW'(1);
    end
  end

  // last accepted word, updated even when the push is dropped
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      last_word <= '0;
    end else if (accept) begin
      last_word <= cand;
    end
  end

  // saturating change counter with synchronous clear
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      change_cnt <= '0;
    end else if (clr) begin
      change_cnt <= accept ? CNT_W'(1) : '0;
    end else if (accept && (change_cnt != '1)) begin
      change_cnt <= change_cnt + CNT_W'(1);
    end
  end

  // sticky debug flags; a set in the clear cycle wins
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      rsvd_err <= 1'b0;
    end else begin
      overflow <= (overflow && !clr) || drop;
      rsvd_err <= (rsvd_err && !clr) || rsvd_set;
    end
  end

  // fifo pointers with wrap bit
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + LW'(1);
      if (pop)  rptr <= rptr + LW'(1);
    end
  end

  // fifo storage, contents qualified by the pointers
  always_ff @(posedge clk_in) begin
    if (push) mem[wptr[AW-1:0]] <= cand;
  end

endmodule

// File: tb/tb_chain_result_capture.sv
// tb_chain_result_capture: directed scenarios plus random
// stimulus against a run-length behavioural model.
module tb_chain_result_capture;

  localparam int DEPTH  = 8;
  localparam int STABLE = 3;
  localparam int RUNSAT = 1000;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic [31:0] data_in = '0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic [3:0]  level;
  logic [15:0] change_cnt;
  logic        overflow;
  logic        rsvd_err;
  logic [54:0] dut_vec;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_h1, m_h2, m_last;
  int          m_run;
  logic [31:0] m_q[$];
  int          m_cnt;
  bit          m_ovf, m_rerr;

  always #5 clk_in = ~clk_in;

  chain_result_capture dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .en        (en),
    .clr       (clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .change_cnt(change_cnt),
    .overflow  (overflow),
    .rsvd_err  (rsvd_err)
  );

  assign dut_vec = {out_data, out_valid, level,
                    change_cnt, overflow, rsvd_err};

  function automatic void model_reset();
    m_h1 = '0;
    m_h2 = '0;
    m_last = '0;
    m_run = RUNSAT;
    m_q.delete();
    m_cnt = 0;
    m_ovf = 0;
    m_rerr = 0;
  endfunction

  // a sampled value qualifies on the cycle its run reaches STABLE+1
  function automatic void model_edge();
    bit qual, pop, acc, fullnp, oset, rset;
    logic [31:0] w;
    qual = (m_run == STABLE + 1);
    w = m_h2;
    pop = (m_q.size() != 0) && out_ready;
    acc = qual && (w != m_last) && en;
    fullnp = (m_q.size() == DEPTH) && !pop;
    rset = qual && (w[7:0] != 8'h00);
    oset = 0;
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      m_last = w;
      if (m_cnt < 65535) m_cnt++;
      if (fullnp) oset = 1;
      else m_q.push_back(w);
    end
    if (clr) begin
      m_cnt = acc ? 1 : 0;
      m_ovf = oset;
      m_rerr = rset;
    end else begin
      m_ovf = m_ovf | oset;
      m_rerr = m_rerr | rset;
    end
    if (m_h1 == m_h2) begin
      if (m_run < RUNSAT) m_run++;
    end else begin
      m_run = 1;
    end
    m_h2 = m_h1;
    m_h1 = data_in;
  endfunction

  function automatic logic [54:0] exp_vec();
    logic [31:0] hd;
    hd = (m_q.size() != 0) ? m_q[0] : 32'h0;
    return {hd, m_q.size() != 0, 4'(m_q.size()),
            16'(m_cnt), m_ovf, m_rerr};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (level !== 4'd0) begin
      failures++;
      $display("FAIL rst_level got=%0d exp=0", level);
    end
    checks++;
    if (change_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_cnt got=%0d exp=0", change_cnt);
    end
    checks++;
    if ({overflow, rsvd_err} !== 2'b00) begin
      failures++;
      $display("FAIL rst_flags got=%b%b exp=00",
               overflow, rsvd_err);
    end
    checks++;
    if (out_data !== 32'h0) begin
      failures++;
      $display("FAIL rst_data got=%h exp=0", out_data);
    end
    rst_n = 1'b1;
    en = 1'b1;
    data_in = 32'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || change_cnt !== 16'd0) begin
        failures++;
        $display("FAIL zero_hold got=%b/%0d exp=0/0",
                 out_valid, change_cnt);
      end
    end
  endtask

  task automatic test_latency();
    int lat;
    lat = -1;
    out_ready = 1'b0;
    data_in = 32'hA5C3_1200;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != STABLE + 3) begin
      failures++;
      $display("FAIL latency got=%0d exp=%0d", lat, STABLE + 3);
    end
    checks++;
    if (out_data !== 32'hA5C3_1200 || level !== 4'd1 ||
        change_cnt !== 16'd1) begin
      failures++;
      $display("FAIL first_word got=%h/%0d/%0d exp=a5c31200/1/1",
               out_data, level, change_cnt);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (level !== 4'd1 || change_cnt !== 16'd1) begin
      failures++;
      $display("FAIL hold_no_repush got=%0d/%0d exp=1/1",
               level, change_cnt);
    end
  endtask

  task automatic test_glitch();
    data_in = 32'hFFFF_FF00;
    tick();
    tick();
    data_in = 32'hA5C3_1200;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (level !== 4'd1 || change_cnt !== 16'd1) begin
      failures++;
      $display("FAIL glitch got=%0d/%0d exp=1/1",
               level, change_cnt);
    end
    data_in = 32'h1111_2200;
    for (int i = 0; i < 4; i++) tick();
    data_in = 32'hA5C3_1200;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (level !== 4'd2 || change_cnt !== 16'd2) begin
      failures++;
      $display("FAIL short_hold got=%0d/%0d exp=2/2",
               level, change_cnt);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL glitch_model got=%h exp=%h",
               dut_vec, exp_vec());
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 20 && out_valid; k++) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] w [9];
    drain();
    checks++;
    if (level !== 4'd0) begin
      failures++;
      $display("FAIL drain_empty got=%0d exp=0", level);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      w[i] = {8'(i + 1), 16'($urandom), 8'h00};
      data_in = w[i];
      for (int j = 0; j < 5; j++) begin
        tick();
        if (i == 8 && j == 2) begin
          checks++;
          if (level !== 4'd8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fill8 got=%0d/%b exp=8/0",
                     level, overflow);
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (level !== 4'd8 || overflow !== 1'b1 ||
        change_cnt !== 16'd9) begin
      failures++;
      $display("FAIL ovf got=%0d/%b/%0d exp=8/1/9",
               level, overflow, change_cnt);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_data !== w[k] || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL drain_order%0d got=%h exp=%h",
                 k, out_data, w[k]);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      failures++;
      $display("FAIL drained got=%b/%h exp=0/0",
               out_valid, out_data);
    end
  endtask

  task automatic test_full_simul();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr got=%b exp=0", overflow);
    end
    for (int i = 0; i < 8; i++) begin
      data_in = {8'(8'h20 + i), 16'($urandom), 8'h00};
      for (int j = 0; j < 5; j++) tick();
    end
    for (int i = 0; i < 3; i++) tick();
    data_in = 32'h7777_6600;
    for (int j = 0; j < 5; j++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (level !== 4'd8 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL push_pop_full got=%0d/%b exp=8/0",
               level, overflow);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL full_model got=%h exp=%h",
               dut_vec, exp_vec());
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (change_cnt !== 16'd0 || overflow !== 1'b0 ||
        rsvd_err !== 1'b0 || level !== 4'd8) begin
      failures++;
      $display("FAIL clr got=%0d/%b/%b/%0d exp=0/0/0/8",
               change_cnt, overflow, rsvd_err, level);
    end
  endtask

  task automatic test_rsvd_reset();
    drain();
    data_in = 32'h0000_00FF;
    for (int j = 0; j < 7; j++) tick();
    checks++;
    if (rsvd_err !== 1'b1 || out_data !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL rsvd got=%b/%h exp=1/000000ff",
               rsvd_err, out_data);
    end
    data_in = 32'h3333_3300;
    for (int j = 0; j < 7; j++) tick();
    data_in = 32'h4444_4400;
    for (int j = 0; j < 7; j++) tick();
    checks++;
    if (level !== 4'd3) begin
      failures++;
      $display("FAIL pre_rst_level got=%0d exp=3", level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || level !== 4'd0 ||
        {overflow, rsvd_err} !== 2'b00 ||
        change_cnt !== 16'd0) begin
      failures++;
      $display("FAIL async_rst got=%b/%0d/%b%b/%0d exp=0/0/00/0",
               out_valid, level, overflow, rsvd_err, change_cnt);
    end
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] pool [4];
    int hold, sel;
    for (int p = 0; p < 4; p++) pool[p] = $urandom;
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 9) == 0) begin
        pool[$urandom_range(0, 3)] = $urandom;
      end
      sel = $urandom_range(0, 3);
      data_in = pool[sel];
      if ($urandom_range(0, 7) != 0) data_in[7:0] = 8'h00;
      hold = $urandom_range(1, 7);
      for (int j = 0; j < hold; j++) begin
        en = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) == 0);
        clr = ($urandom_range(0, 31) == 0);
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
          failures++;
          $display("FAIL random seg=%0d got=%h exp=%h",
                   seg, dut_vec, exp_vec());
        end
      end
    end
    en = 1'b1;
    clr = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_glitch();
    test_overflow();
    test_full_simul();
    test_rsvd_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
